// File: rtl/dhdw_seq_accum.sv
// Time-step sequencer and gradient accumulator for the dh_t/dw derivative stage.
// Issues one step_en per step, feeds back dh(t-1)/dw and accumulates err_t * dh_t/dw.

module dhdw_seq_accum #(
    parameter int DATABIT = 16,
    parameter int FRAC    = 8,
    parameter int CELLNUM = 4,
    parameter int SEQLEN  = 8,
    parameter int CNTW    = 4,
    parameter int ACCBIT  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               res_valid,
    input  logic [DATABIT-1:0] res_0,
    input  logic [DATABIT-1:0] res_1,
    input  logic [DATABIT-1:0] res_2,
    input  logic [DATABIT-1:0] res_3,
    input  logic [DATABIT-1:0] err_0,
    input  logic [DATABIT-1:0] err_1,
    input  logic [DATABIT-1:0] err_2,
    input  logic [DATABIT-1:0] err_3,
    output logic               step_en,
    output logic [CNTW-1:0]    step_idx,
    output logic [DATABIT-1:0] dh0_dw,
    output logic [DATABIT-1:0] dh1_dw,
    output logic [DATABIT-1:0] dh2_dw,
    output logic [DATABIT-1:0] dh3_dw,
    output logic               busy,
    output logic               grad_valid,
    output logic [ACCBIT-1:0]  grad_0,
    output logic [ACCBIT-1:0]  grad_1,
    output logic [ACCBIT-1:0]  grad_2,
    output logic [ACCBIT-1:0]  grad_3,
    output logic               timeout_err
);

    localparam int PW   = 2 * DATABIT;
    localparam int WIDE = (ACCBIT > PW) ? ACCBIT : PW;
    localparam int WCW  = $clog2(TIMEOUT + 1);

    localparam logic [CNTW-1:0]         LAST_STEP = CNTW'(SEQLEN - 1);
    localparam logic [WCW-1:0]          WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic signed [ACCBIT-1:0] ACC_MAX  = {1'b0, {(ACCBIT-1){1'b1}}};
    localparam logic signed [ACCBIT-1:0] ACC_MIN  = {1'b1, {(ACCBIT-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Full-precision product rescaled by FRAC; the arithmetic shift floors toward minus infinity.
    function automatic logic signed [ACCBIT-1:0] scaled_product(
        input logic signed [DATABIT-1:0] a,
        input logic signed [DATABIT-1:0] b
    );
        logic signed [PW-1:0]   prod;
        logic signed [WIDE-1:0] wide;
        prod = PW'(a) * PW'(b);
        wide = WIDE'(prod) >>> FRAC;
        return ACCBIT'(wide);
    endfunction

    // One guard bit detects overflow; the sign of the true sum picks the clamp rail.
    function automatic logic signed [ACCBIT-1:0] sat_add(
        input logic signed [ACCBIT-1:0] acc,
        input logic signed [ACCBIT-1:0] p
    );
        logic signed [ACCBIT:0]   sum;
        logic signed [ACCBIT-1:0] result;
        sum = (ACCBIT+1)'(acc) + (ACCBIT+1)'(p);
        if (sum[ACCBIT] == sum[ACCBIT-1]) begin
            result = sum[ACCBIT-1:0];
        end else if (sum[ACCBIT]) begin
            result = ACC_MIN;
        end else begin
            result = ACC_MAX;
        end
        return result;
    endfunction

    state_t                    state_r;
    state_t                    state_nxt;
    logic [CNTW-1:0]           step_idx_r;
    logic [WCW-1:0]            wait_cnt_r;
    logic [DATABIT-1:0]        dh_r      [CELLNUM];
    logic signed [ACCBIT-1:0]  acc_r     [CELLNUM];
    logic signed [ACCBIT-1:0]  acc_nxt_s [CELLNUM];
    logic signed [DATABIT-1:0] res_s     [CELLNUM];
    logic signed [DATABIT-1:0] err_s     [CELLNUM];
    logic                      start_s;
    logic                      accept_s;
    logic                      timeout_s;
    logic                      step_en_r;
    logic                      busy_r;
    logic                      grad_valid_r;
    logic                      timeout_err_r;

    assign res_s[0] = res_0;
    assign res_s[1] = res_1;
    assign res_s[2] = res_2;
    assign res_s[3] = res_3;
    assign err_s[0] = err_0;
    assign err_s[1] = err_1;
    assign err_s[2] = err_2;
    assign err_s[3] = err_3;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state decode; a result arriving on the last wait cycle still beats the timeout.
    always_comb begin
        state_nxt = state_r;
        start_s   = 1'b0;
        accept_s  = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    start_s   = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (res_valid) begin
                    accept_s = 1'b1;
                    if (step_idx_r == LAST_STEP) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end else if (wait_cnt_r == WAIT_LAST) begin
                    timeout_s = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Candidate accumulator values for the current result beat.
    always_comb begin
        for (int i = 0; i < CELLNUM; i++) begin
            acc_nxt_s[i] = sat_add(acc_r[i], scaled_product(err_s[i], res_s[i]));
        end
    end

    // Step index, wait counter, fed-back derivatives and accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_idx_r <= {CNTW{1'b0}};
            wait_cnt_r <= {WCW{1'b0}};
            for (int i = 0; i < CELLNUM; i++) begin
                dh_r[i]  <= {DATABIT{1'b0}};
                acc_r[i] <= {ACCBIT{1'b0}};
            end
        end else if (start_s) begin
            step_idx_r <= {CNTW{1'b0}};
            wait_cnt_r <= {WCW{1'b0}};
            for (int i = 0; i < CELLNUM; i++) begin
                dh_r[i]  <= {DATABIT{1'b0}};
                acc_r[i] <= {ACCBIT{1'b0}};
            end
        end else if (accept_s) begin
            for (int i = 0; i < CELLNUM; i++) begin
                dh_r[i]  <= res_s[i];
                acc_r[i] <= acc_nxt_s[i];
            end
            if (step_idx_r != LAST_STEP) begin
                step_idx_r <= step_idx_r + CNTW'(1);
                wait_cnt_r <= {WCW{1'b0}};
            end
        end else if ((state_r == WAIT) && !timeout_s) begin
            wait_cnt_r <= wait_cnt_r + WCW'(1);
        end
    end

    // Control outputs registered from the next state so they align with state_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_en_r     <= 1'b0;
            busy_r        <= 1'b0;
            grad_valid_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            step_en_r     <= (state_nxt == ISSUE);
            busy_r        <= (state_nxt != IDLE);
            grad_valid_r  <= (state_nxt == DONE);
            timeout_err_r <= timeout_s;
        end
    end

    assign step_en     = step_en_r;
    assign step_idx    = step_idx_r;
    assign busy        = busy_r;
    assign grad_valid  = grad_valid_r;
    assign timeout_err = timeout_err_r;
    assign dh0_dw      = dh_r[0];
    assign dh1_dw      = dh_r[1];
    assign dh2_dw      = dh_r[2];
    assign dh3_dw      = dh_r[3];
    assign grad_0      = acc_r[0];
    assign grad_1      = acc_r[1];
    assign grad_2      = acc_r[2];
    assign grad_3      = acc_r[3];

endmodule

// File: tb/tb_dhdw_seq_accum.sv
// Scoreboard bench for dhdw_seq_accum: a driver pushes model expectations per step and
// per sequence, a negedge monitor pops them whenever step_en, grad_valid or timeout_err fire.

module tb_dhdw_seq_accum;

    localparam int DATABIT = 16;
    localparam int FRAC    = 8;
    localparam int CELLNUM = 4;
    localparam int SEQLEN  = 4;
    localparam int CNTW    = 4;
    localparam int ACCBIT  = 24;
    localparam int TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               res_valid;
    logic [DATABIT-1:0] res_a [4];
    logic [DATABIT-1:0] err_a [4];
    logic               step_en;
    logic [CNTW-1:0]    step_idx;
    logic [DATABIT-1:0] dh0_dw, dh1_dw, dh2_dw, dh3_dw;
    logic               busy;
    logic               grad_valid;
    logic [ACCBIT-1:0]  grad_0, grad_1, grad_2, grad_3;
    logic               timeout_err;

    logic signed [DATABIT-1:0] dh_mon   [4];
    logic signed [ACCBIT-1:0]  grad_mon [4];
    assign dh_mon[0]   = dh0_dw;
    assign dh_mon[1]   = dh1_dw;
    assign dh_mon[2]   = dh2_dw;
    assign dh_mon[3]   = dh3_dw;
    assign grad_mon[0] = grad_0;
    assign grad_mon[1] = grad_1;
    assign grad_mon[2] = grad_2;
    assign grad_mon[3] = grad_3;

    dhdw_seq_accum #(
        .DATABIT(DATABIT), .FRAC(FRAC), .CELLNUM(CELLNUM), .SEQLEN(SEQLEN),
        .CNTW(CNTW), .ACCBIT(ACCBIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .res_valid(res_valid),
        .res_0(res_a[0]), .res_1(res_a[1]), .res_2(res_a[2]), .res_3(res_a[3]),
        .err_0(err_a[0]), .err_1(err_a[1]), .err_2(err_a[2]), .err_3(err_a[3]),
        .step_en(step_en), .step_idx(step_idx),
        .dh0_dw(dh0_dw), .dh1_dw(dh1_dw), .dh2_dw(dh2_dw), .dh3_dw(dh3_dw),
        .busy(busy), .grad_valid(grad_valid),
        .grad_0(grad_0), .grad_1(grad_1), .grad_2(grad_2), .grad_3(grad_3),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     idx;
        longint dh[4];
        longint grad[4];
    } step_exp_t;

    typedef struct {
        longint grad[4];
    } grad_exp_t;

    step_exp_t step_q[$];
    grad_exp_t grad_q[$];
    int        to_q[$];
    step_exp_t mon_e;
    grad_exp_t mon_g;

    longint sres [SEQLEN][4];
    longint serr [SEQLEN][4];
    int     slat [SEQLEN];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference arithmetic: real-valued rule with floor division and clamping.
    function automatic longint prod_term(input longint e, input longint r);
        return (e * r) >>> FRAC;
    endfunction

    function automatic longint clamp(input longint v);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (ACCBIT - 1)) - 1;
        lo = -(longint'(1) <<< (ACCBIT - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint rand_word();
        logic signed [DATABIT-1:0] w;
        w = DATABIT'($urandom);
        return longint'(w);
    endfunction

    task automatic drive_junk();
        for (int i = 0; i < 4; i++) begin
            res_a[i] = DATABIT'($urandom);
            err_a[i] = DATABIT'($urandom);
        end
    endtask

    task automatic fill_const(input longint r, input longint e, input int lat);
        for (int k = 0; k < SEQLEN; k++) begin
            slat[k] = lat;
            for (int i = 0; i < 4; i++) begin
                sres[k][i] = r;
                serr[k][i] = e;
            end
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < SEQLEN; k++) begin
            slat[k] = $urandom_range(20, 1);
            for (int i = 0; i < 4; i++) begin
                sres[k][i] = rand_word();
                serr[k][i] = rand_word();
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_step_en"}, longint'(step_en), 0);
        check({tag, "_step_idx"}, longint'(step_idx), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_grad_valid"}, longint'(grad_valid), 0);
        check({tag, "_timeout_err"}, longint'(timeout_err), 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_dh%0d", tag, i), longint'(dh_mon[i]), 0);
            check($sformatf("%s_grad%0d", tag, i), longint'(grad_mon[i]), 0);
        end
    endtask

    task automatic wait_step_en(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (step_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL step_en_wait: got no step_en within 200 cycles, expected one");
        end
    endtask

    // stop_kind: 0 full sequence, 1 reset during WAIT of stop_step, 2 withhold result at stop_step.
    task automatic run_seq(input bit hold_start, input bit spurious, input int stop_kind, input int stop_step);
        longint    acc[4];
        step_exp_t e;
        grad_exp_t g;
        int        n_steps;
        bit        ok;
        n_steps = (stop_kind == 0) ? SEQLEN : stop_step + 1;
        for (int i = 0; i < 4; i++) acc[i] = 0;
        for (int k = 0; k < n_steps; k++) begin
            e.idx = k;
            for (int i = 0; i < 4; i++) begin
                e.dh[i]   = (k == 0) ? 0 : sres[k-1][i];
                e.grad[i] = acc[i];
                acc[i]    = clamp(acc[i] + prod_term(serr[k][i], sres[k][i]));
            end
            step_q.push_back(e);
        end
        if (stop_kind == 0) begin
            for (int i = 0; i < 4; i++) g.grad[i] = acc[i];
            grad_q.push_back(g);
        end
        if (stop_kind == 2) to_q.push_back(stop_step);

        start = 1'b1;
        res_valid = spurious;
        drive_junk();
        @(posedge clk);
        #1;
        check("step_en_after_start", longint'(step_en), 1);
        if (!hold_start) start = 1'b0;

        for (int k = 0; k < n_steps; k++) begin
            wait_step_en(ok);
            if (!ok) begin
                start = 1'b0;
                res_valid = 1'b0;
                return;
            end
            if (stop_kind == 1 && k == stop_step) begin
                @(posedge clk);
                #1;
                res_valid = 1'b0;
                drive_junk();
                @(posedge clk);
                #2;
                rst = 1'b1;
                #1;
                check_all_zero("mid_reset");
                start = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            if (stop_kind == 2 && k == stop_step) begin
                @(posedge clk);
                #1;
                res_valid = 1'b0;
                drive_junk();
                repeat (63) @(posedge clk);
                #1;
                check("busy_before_timeout", longint'(busy), 1);
                check("timeout_early", longint'(timeout_err), 0);
                @(posedge clk);
                #1;
                check("timeout_pulse", longint'(timeout_err), 1);
                check("busy_after_timeout", longint'(busy), 0);
                @(posedge clk);
                #1;
                check("timeout_single", longint'(timeout_err), 0);
                check("grad_valid_after_timeout", longint'(grad_valid), 0);
                start = 1'b0;
                return;
            end
            for (int j = 1; j <= slat[k]; j++) begin
                @(posedge clk);
                #1;
                if (j == slat[k]) begin
                    res_valid = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        res_a[i] = DATABIT'(sres[k][i]);
                        err_a[i] = DATABIT'(serr[k][i]);
                    end
                end else begin
                    res_valid = 1'b0;
                    drive_junk();
                end
            end
            @(posedge clk);
            #1;
            res_valid = 1'b0;
            drive_junk();
        end

        check("grad_valid_at_done", longint'(grad_valid), 1);
        start = 1'b0;
        res_valid = spurious;
        @(posedge clk);
        #1;
        check("grad_valid_single", longint'(grad_valid), 0);
        check("busy_after_done", longint'(busy), 0);
        drive_junk();
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dh%0d_hold", i), longint'(dh_mon[i]), sres[SEQLEN-1][i]);
            check($sformatf("grad%0d_hold", i), longint'(grad_mon[i]), acc[i]);
        end
    endtask

    // Monitor: every observed output event must match the oldest pending expectation.
    always @(negedge clk) begin
        if (step_en === 1'b1) begin
            if (step_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_step_en: got step_en=1 at step_idx %0d, expected 0", step_idx);
            end else begin
                mon_e = step_q.pop_front();
                check("step_idx", longint'(step_idx), longint'(mon_e.idx));
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("dh%0d_dw_s%0d", i, mon_e.idx), longint'(dh_mon[i]), mon_e.dh[i]);
                    check($sformatf("grad%0d_partial_s%0d", i, mon_e.idx), longint'(grad_mon[i]), mon_e.grad[i]);
                end
            end
        end
        if (grad_valid === 1'b1) begin
            if (grad_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_grad_valid: got grad_valid=1, expected 0");
            end else begin
                mon_g = grad_q.pop_front();
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("grad%0d_final", i), longint'(grad_mon[i]), mon_g.grad[i]);
                end
            end
        end
        if (timeout_err === 1'b1) begin
            n_tests++;
            if (to_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_timeout_err: got timeout_err=1, expected 0");
            end else begin
                void'(to_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by 1000000 ns, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            res_a[i] = '0;
            err_a[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("idle");

        res_valid = 1'b1;
        drive_junk();
        repeat (3) @(posedge clk);
        #1;
        res_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("idle_spurious_dh%0d", i), longint'(dh_mon[i]), 0);
            check($sformatf("idle_spurious_grad%0d", i), longint'(grad_mon[i]), 0);
        end

        fill_const(256, 512, 18);
        run_seq(1'b0, 1'b0, 0, 0);

        fill_const(-256, 256, 5);
        for (int k = 0; k < SEQLEN; k++) begin
            sres[k][0] = -1;
            serr[k][0] = 1;
        end
        run_seq(1'b0, 1'b0, 0, 0);

        fill_const(32767, 32767, 3);
        run_seq(1'b0, 1'b0, 0, 0);

        fill_const(32767, -32768, 1);
        run_seq(1'b0, 1'b0, 0, 0);

        fill_random();
        run_seq(1'b0, 1'b0, 2, 0);
        fill_random();
        run_seq(1'b0, 1'b0, 0, 0);

        fill_random();
        run_seq(1'b1, 1'b1, 0, 0);

        fill_random();
        run_seq(1'b0, 1'b0, 1, 2);
        repeat (40) @(posedge clk);
        #1;
        check_all_zero("post_reset");

        for (int n = 0; n < 20; n++) begin
            fill_random();
            run_seq(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0, 0);
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        check("step_q_drained", longint'(step_q.size()), 0);
        check("grad_q_drained", longint'(grad_q.size()), 0);
        check("timeout_q_drained", longint'(to_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
